// File: rtl/dram_responder.sv
// dram_responder: data-memory responder at the far end of the processor's
// data-memory interface. Owns a DEPTH x DATA_W storage array and services one
// read or write request at a time. The access happens LATENCY edges after the
// request is accepted; the response is then held until the consumer takes it.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_we           1 = write, 0 = read
//   req_addr         word address (low log2(DEPTH) bits index the array)
//   req_wdata        write data
//   resp_valid/ready response handshake (valid held in RESP)
//   resp_rdata       read data, or the echoed write data
//   resp_err         address error flag
//   busy             high while in WAIT or RESP
//
// Optional feature, macro DRAM_ADDR_CHECK_EN:
//   defined   - requests with req_addr >= DEPTH suppress the write, read back
//               0 and raise resp_err.
//   undefined - resp_err is tied to 0 and upper address bits alias.
module dram_responder #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_we;

    // Storage array; deliberately not reset.
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef DRAM_ADDR_CHECK_EN
    logic                oor_q, oor_d;
    logic                err_q, err_d;
`else
    // Upper address bits only matter with the address check enabled.
    logic                unused_addr;
    assign unused_addr = ^req_addr;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef DRAM_ADDR_CHECK_EN
        oor_d   = oor_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = req_addr[IDX_W-1:0];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
`ifdef DRAM_ADDR_CHECK_EN
                    oor_d   = (req_addr >> IDX_W) != '0;
`endif
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge.
`ifdef DRAM_ADDR_CHECK_EN
                    err_d = oor_q;
                    if (we_q) begin
                        mem_we  = !oor_q;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = oor_q ? '0 : mem[idx_q];
                    end
`else
                    mem_we  = we_q;
                    rdata_d = we_q ? wdata_q : mem[idx_q];
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DRAM_ADDR_CHECK_EN
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DRAM_ADDR_CHECK_EN
            oor_q   <= oor_d;
            err_q   <= err_d;
`endif
        end
    end

    // A reset landing on the access edge abandons the write.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) mem[idx_q] <= wdata_q;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_rdata = rdata_q;
`ifdef DRAM_ADDR_CHECK_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder. Instance 0 uses LATENCY=2, instance 1
// uses LATENCY=1. Expected responses are queued at issue time and a monitor
// pops and compares them on every completed response handshake.
module tb_dram_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [11:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        busy       [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [32:0] exp0[$];
    logic [32:0] exp1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_responder #(.LATENCY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    dram_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every completed response against the scoreboard.
    always @(negedge clk) begin
        logic [32:0] e;
        if (resp_valid[0] && resp_ready[0]) begin
            total++;
            if (exp0.size() == 0) begin
                bad++;
                $display("FAIL resp0_unexpected: got %0h expected none", resp_rdata[0]);
            end else begin
                e = exp0.pop_front();
                if ({resp_err[0], resp_rdata[0]} !== e) begin
                    bad++;
                    $display("FAIL resp0: got %0h expected %0h", {resp_err[0], resp_rdata[0]}, e);
                end
            end
        end
        if (resp_valid[1] && resp_ready[1]) begin
            total++;
            if (exp1.size() == 0) begin
                bad++;
                $display("FAIL resp1_unexpected: got %0h expected none", resp_rdata[1]);
            end else begin
                e = exp1.pop_front();
                if ({resp_err[1], resp_rdata[1]} !== e) begin
                    bad++;
                    $display("FAIL resp1: got %0h expected %0h", {resp_err[1], resp_rdata[1]}, e);
                end
            end
        end
    end

    // Issue one request, push its expected response, and check that
    // resp_valid rises exactly LATENCY edges after acceptance.
    task automatic txn(input int i, input logic we, input logic [11:0] a,
                       input logic [31:0] d, input logic [32:0] exp, output int acc);
        bit ok;
        int lat;
        lat = (i == 0) ? 2 : 1;
        if (i == 0) exp0.push_back(exp); else exp1.push_back(exp);
        @(negedge clk);
        req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
        ok = 0; acc = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (req_ready[i]) begin ok = 1; acc = cyc + 1; end
            else @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no req_ready expected req_ready");
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (resp_valid[i]) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL resp_timeout: got no resp_valid expected resp_valid");
        end else begin
            chk("latency", 64'(cyc - acc), 64'(lat));
        end
    endtask

    int acc;
    int accs [4];
    logic [31:0] tp_data [4];
    bit ok;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        tp_data[0] = 32'h0BAD_F00D; tp_data[1] = 32'h1357_9BDF;
        tp_data[2] = 32'h2468_ACE0; tp_data[3] = 32'hFFFF_0001;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; resp_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", req_ready[i], 1);
            chk("rst_resp_valid", resp_valid[i], 0);
            chk("rst_resp_rdata", resp_rdata[i], 0);
            chk("rst_resp_err", resp_err[i], 0);
            chk("rst_busy", busy[i], 0);
        end
        rst_n = 1'b1;

        // Write then read, LATENCY=2.
        txn(0, 1'b1, 12'h010, 32'hDEADBEEF, {1'b0, 32'hDEADBEEF}, acc);
        txn(0, 1'b0, 12'h010, 32'h0, {1'b0, 32'hDEADBEEF}, acc);

        // Backpressure: response held, stray request ignored.
        @(posedge clk); #1 resp_ready[0] = 1'b0;
        txn(0, 1'b0, 12'h010, 32'h0, {1'b0, 32'hDEADBEEF}, acc);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", resp_valid[0], 1);
            chk("bp_rdata", resp_rdata[0], 32'hDEADBEEF);
            chk("bp_req_ready", req_ready[0], 0);
            if (k == 1) begin
                req_valid[0] = 1'b1; req_we[0] = 1'b1;
                req_addr[0] = 12'h010; req_wdata[0] = 32'h1111_1111;
            end
            if (k == 2) req_valid[0] = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1 resp_ready[0] = 1'b1;
        txn(0, 1'b0, 12'h010, 32'h0, {1'b0, 32'hDEADBEEF}, acc);

        // Reset while in WAIT abandons the write.
        txn(0, 1'b1, 12'h020, 32'hAAAA5555, {1'b0, 32'hAAAA5555}, acc);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0] = 12'h020; req_wdata[0] = 32'h1234_5678;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (req_ready[0]) ok = 1;
            else @(negedge clk);
        end
        chk("midrst_accept", ok, 1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("midrst_busy_wait", busy[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_req_ready", req_ready[0], 1);
        chk("midrst_resp_valid", resp_valid[0], 0);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_rdata", resp_rdata[0], 0);
        txn(0, 1'b0, 12'h020, 32'h0, {1'b0, 32'hAAAA5555}, acc);

        // Out-of-range address: alias or error depending on build.
        txn(0, 1'b1, 12'h005, 32'h0000_5A5A, {1'b0, 32'h0000_5A5A}, acc);
`ifdef DRAM_ADDR_CHECK_EN
        txn(0, 1'b1, 12'h105, 32'h0000_CAFE, {1'b1, 32'h0000_CAFE}, acc);
        txn(0, 1'b0, 12'h005, 32'h0, {1'b0, 32'h0000_5A5A}, acc);
        txn(0, 1'b0, 12'h105, 32'h0, {1'b1, 32'h0}, acc);
`else
        txn(0, 1'b1, 12'h105, 32'h0000_CAFE, {1'b0, 32'h0000_CAFE}, acc);
        txn(0, 1'b0, 12'h005, 32'h0, {1'b0, 32'h0000_CAFE}, acc);
`endif

        // Throughput, LATENCY=1: acceptances 3 edges apart.
        for (int k = 0; k < 4; k++)
            txn(1, 1'b1, 12'(8'h40 + k), tp_data[k], {1'b0, tp_data[k]}, accs[k]);
        for (int k = 1; k < 4; k++)
            chk("tp_spacing", 64'(accs[k] - accs[k-1]), 3);
        for (int k = 0; k < 4; k++)
            txn(1, 1'b0, 12'(8'h40 + k), 32'h0, {1'b0, tp_data[k]}, acc);

        repeat (5) @(negedge clk);
        chk("sb0_drained", exp0.size(), 0);
        chk("sb1_drained", exp1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Data-memory responder on the far end of the processor's data-memory interface.
- Accepts one read or write request at a time (address from AR, write data from DR, write enable) through a valid/ready handshake.
- Performs the access after a programmable number of wait states and returns read data with a held response handshake.
- Sits between the processor core and the data-memory array; owns the 32-bit storage array itself.

Parameters:
- ADDR_W, 12, request address width; matches the 12-bit AR.
- DATA_W, 32, word width; matches the 32-bit DR and Data bus.
- DEPTH, 256, number of words stored; must be a power of two and ≤ 2^ADDR_W.
- LATENCY, 2, wait states between request acceptance and the access; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  DATA_W  read data, or the echoed write data.
- resp_err  output  1  address error; constant 0 unless DRAM_ADDR_CHECK_EN is defined.
- busy  output  1  high in WAIT or RESP.

Behaviour:
- Reset: one clock and one reset. The reset is synchronous and active-low: rst_n low at a rising edge of clk forces the reset state.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, wait counter = 0.
- Reset does not clear the memory array.
- Reset mid-operation: a request in WAIT or RESP is abandoned. A write that has not yet reached its access edge is not performed.
- FSM state IDLE: req_ready = 1. On req_valid && req_ready, latch addr, we and wdata, load counter = LATENCY-1, then go to WAIT.
- FSM state WAIT: req_ready = 0. If counter ≠ 0, decrement it. If counter = 0 (the access edge):
  - write: mem[addr] ← wdata, resp_rdata ← wdata.
  - read: resp_rdata ← mem[addr].
  - then go to RESP.
- FSM state RESP: resp_valid = 1, with resp_rdata and resp_err stable. On resp_ready, go to IDLE and drop resp_valid.
- While resp_ready is low, RESP holds indefinitely and the response values do not change.
- Timing: with acceptance at edge t, the access happens at edge t+LATENCY and resp_valid is high from that edge.
- Minimum request-to-request spacing is LATENCY+2 edges: acceptance, LATENCY edges to the access, then an edge back to IDLE. req_ready is low for LATENCY+1 cycles.
- No pipelining: while not in IDLE, req_valid is ignored. The request is not captured and the requester must hold it.
- req_valid and resp_ready may both be high in RESP. Only the response completes; the new request is accepted on the next IDLE cycle.
- Addressing: the index is req_addr[log2(DEPTH)-1:0]. Upper address bits are ignored unless the optional feature is enabled.
- Read of a never-written location returns the array's uninitialised contents. The bench must write a location before reading it.
- Read-after-write to the same address in back-to-back requests returns the new data.

Optional Feature:
- Macro DRAM_ADDR_CHECK_EN.
- Defined:
  - A request with req_addr ≥ DEPTH is still accepted and timed normally.
  - At the access edge, a write is suppressed and a read returns 0.
  - resp_err = 1 for that response; resp_err = 0 for in-range requests.
- Not defined:
  - resp_err is tied to 0.
  - Out-of-range addresses alias modulo DEPTH. With DEPTH = 256, address 0x105 accesses word 0x05.

Test Plan:
- Reset then idle: rst_n low for 2 edges → req_ready = 1, resp_valid = 0, resp_rdata = 0, busy = 0.
- Write then read, LATENCY = 2: write addr 0x010, data 0xDEADBEEF, accepted at edge 0 → resp_valid at edge 2 with echo 0xDEADBEEF. After resp_ready, read 0x010 → resp_rdata = 0xDEADBEEF, resp_valid exactly 2 edges after acceptance.
- Backpressure: read response with resp_ready held low for 5 cycles → resp_valid and resp_rdata stable throughout, req_ready = 0. A req_valid pulse during this time is not captured and no write occurs.
- Reset mid-operation: write addr 0x020, data 0x12345678, rst_n low at the edge after acceptance (state WAIT) → later read of 0x020 returns its prior value 0xAAAA5555, written earlier, and the FSM is in IDLE.
- Aliasing / feature check, DEPTH = 256:
  - macro off: write 0x105 with 0x0000CAFE, then read 0x005 → 0x0000CAFE, resp_err = 0.
  - macro on: the same write gives resp_err = 1 and 0x005 is unchanged.
- Throughput, LATENCY = 1: 4 back-to-back writes with resp_ready tied high → acceptances spaced exactly 3 edges apart, and all 4 words read back correctly.
